hazard_unit: RTL and testbench

- Pipeline hazard controller. It generates the is_bubbling stall consumed by the ID-stage control, the stage flush/bubble controls, the PC load enable, and a post-branch squash window.
- Detects load-use hazards between ID and EX, taken-branch redirects resolved in EX, and instruction/data memory wait conditions.
- One instance per core, sitting beside the IF/ID/EX/MEM/WB stage registers.

---
 rtl/hazard_unit.sv | 171 +++++++++++++++++
 tb/tb_hazard_unit.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flushes, memory-wait freezes
// and the post-redirect squash window, plus stall/flush performance counters.
module hazard_unit #(
    parameter int LOAD_USE_CYCLES = 1,
    parameter int FLUSH_DEPTH     = 2,
    parameter int CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             ex_br_taken,
    input  logic             imem_resp,
    input  logic             dmem_req,
    input  logic             dmem_resp,
    output logic             is_bubbling,
    output logic             ex_bubble,
    output logic             freeze,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             pc_load_en,
    output logic             squash_active,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int LU_W = 2;
    localparam int SQ_W = 3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_LOAD_USE = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [LU_W-1:0]   lu_cnt_r;
    logic [LU_W-1:0]   lu_cnt_nx_s;
    logic [SQ_W-1:0]   squash_cnt_r;
    logic [CNT_W-1:0]  stall_r;
    logic [CNT_W-1:0]  flush_r;

    logic mem_wait_s;
    logic hazard_s;
    logic bubble_s;
    logic ex_bubble_s;
    logic freeze_s;
    logic flush_s;
    logic pc_en_s;
    logic squash_load_s;

    function automatic logic src_match(input logic uses, input logic [4:0] rs, input logic [4:0] rd);
        return uses & (rs == rd);
    endfunction

    assign mem_wait_s = ~imem_resp | (dmem_req & ~dmem_resp);
    // x0 is hardwired to zero, so a load targeting it never feeds a consumer
    assign hazard_s   = ex_is_load & (ex_rd != 5'd0) &
                        (src_match(id_uses_rs1, id_rs1, ex_rd) | src_match(id_uses_rs2, id_rs2, ex_rd));

    // Per-cycle control decode; MEM_WAIT resolves exactly like RUN once memory is ready
    always_comb begin
        bubble_s      = 1'b0;
        ex_bubble_s   = 1'b0;
        freeze_s      = 1'b0;
        flush_s       = 1'b0;
        pc_en_s       = 1'b0;
        squash_load_s = 1'b0;
        state_nx_s    = state_r;
        lu_cnt_nx_s   = lu_cnt_r;
        case (state_r)
            ST_LOAD_USE: begin
                bubble_s    = 1'b1;
                ex_bubble_s = 1'b1;
                if (mem_wait_s) begin
                    freeze_s = 1'b1;
                end else if (lu_cnt_r <= 2'd1) begin
                    lu_cnt_nx_s = 2'd0;
                    state_nx_s  = ST_RUN;
                end else begin
                    lu_cnt_nx_s = lu_cnt_r - 2'd1;
                end
            end
            ST_RUN, ST_MEM_WAIT: begin
                if (mem_wait_s) begin
                    freeze_s   = 1'b1;
                    bubble_s   = 1'b1;
                    state_nx_s = ST_MEM_WAIT;
                end else if (ex_br_taken) begin
                    flush_s       = 1'b1;
                    pc_en_s       = 1'b1;
                    squash_load_s = 1'b1;
                    state_nx_s    = ST_RUN;
                end else if (hazard_s) begin
                    bubble_s    = 1'b1;
                    ex_bubble_s = 1'b1;
                    if (LOAD_USE_CYCLES > 1) begin
                        lu_cnt_nx_s = LU_W'(LOAD_USE_CYCLES - 1);
                        state_nx_s  = ST_LOAD_USE;
                    end else begin
                        state_nx_s  = ST_RUN;
                    end
                end else begin
                    pc_en_s    = 1'b1;
                    state_nx_s = ST_RUN;
                end
            end
            default: begin
                state_nx_s  = ST_RUN;
                lu_cnt_nx_s = 2'd0;
            end
        endcase
    end

    // FSM, load-use countdown and squash window; the window only drains on advancing cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_RUN;
            lu_cnt_r     <= 2'd0;
            squash_cnt_r <= 3'd0;
        end else begin
            state_r  <= state_nx_s;
            lu_cnt_r <= lu_cnt_nx_s;
            if (squash_load_s) begin
                squash_cnt_r <= SQ_W'(FLUSH_DEPTH);
            end else if (!freeze_s && (squash_cnt_r != 3'd0)) begin
                squash_cnt_r <= squash_cnt_r - 3'd1;
            end else begin
                squash_cnt_r <= squash_cnt_r;
            end
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_r <= {CNT_W{1'b0}};
            flush_r <= {CNT_W{1'b0}};
        end else begin
            if (bubble_s && (stall_r != {CNT_W{1'b1}})) begin
                stall_r <= stall_r + CNT_W'(1);
            end else begin
                stall_r <= stall_r;
            end
            if (squash_load_s && (flush_r != {CNT_W{1'b1}})) begin
                flush_r <= flush_r + CNT_W'(1);
            end else begin
                flush_r <= flush_r;
            end
        end
    end

    // Controls must act in the cycle the condition appears, so they are gated by reset rather than registered
    assign is_bubbling   = rst & bubble_s;
    assign ex_bubble     = rst & ex_bubble_s;
    assign freeze        = rst & freeze_s;
    assign flush_if_id   = rst & flush_s;
    assign flush_id_ex   = rst & flush_s;
    assign pc_load_en    = rst & pc_en_s;
    assign squash_active = rst & (squash_cnt_r != 3'd0);
    assign state_o       = rst ? state_r : 2'd0;
    assign stall_cycles  = stall_r;
    assign flush_count   = flush_r;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: two instances (default and LOAD_USE=3/FLUSH=3/CNT_W=4)
// compared against a cycle-level behavioural model.
module tb_hazard_unit;
    logic clk = 1'b0;
    logic rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic id_uses_rs1, id_uses_rs2, ex_is_load, ex_br_taken, imem_resp, dmem_req, dmem_resp;

    logic a_bub, a_exb, a_frz, a_fif, a_fie, a_pc, a_sqa;
    logic [1:0]  a_state;
    logic [31:0] a_stall, a_flush;
    logic b_bub, b_exb, b_frz, b_fif, b_fie, b_pc, b_sqa;
    logic [1:0]  b_state;
    logic [3:0]  b_stall, b_flush;

    int vectors = 0;
    int miscompares = 0;

    // model state: remaining LOAD_USE cycles, squash cycles, counters, "waited last cycle" flag
    int    lu_rem[2];
    int    sq[2];
    longint stall[2];
    longint flushes[2];
    bit    pmw[2];
    int    luc[2]  = '{1, 3};
    int    fd[2]   = '{2, 3};
    longint maxc[2] = '{64'd4294967295, 64'd15};

    hazard_unit dut_a (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .is_bubbling(a_bub), .ex_bubble(a_exb), .freeze(a_frz), .flush_if_id(a_fif),
        .flush_id_ex(a_fie), .pc_load_en(a_pc), .squash_active(a_sqa), .state_o(a_state),
        .stall_cycles(a_stall), .flush_count(a_flush)
    );

    hazard_unit #(.LOAD_USE_CYCLES(3), .FLUSH_DEPTH(3), .CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_uses_rs1(id_uses_rs1),
        .id_uses_rs2(id_uses_rs2), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_br_taken(ex_br_taken),
        .imem_resp(imem_resp), .dmem_req(dmem_req), .dmem_resp(dmem_resp),
        .is_bubbling(b_bub), .ex_bubble(b_exb), .freeze(b_frz), .flush_if_id(b_fif),
        .flush_id_ex(b_fie), .pc_load_en(b_pc), .squash_active(b_sqa), .state_o(b_state),
        .stall_cycles(b_stall), .flush_count(b_flush)
    );

    always #5 clk = ~clk;

    function automatic logic mwait();
        return !imem_resp || (dmem_req && !dmem_resp);
    endfunction

    function automatic logic hz();
        return ex_is_load && (ex_rd != 5'd0) &&
               ((id_uses_rs1 && id_rs1 == ex_rd) || (id_uses_rs2 && id_rs2 == ex_rd));
    endfunction

    // {bubbling, ex_bubble, freeze, flush_if_id, flush_id_ex, pc_load_en, squash_active, state[1:0]}
    function automatic logic [8:0] exp_vec(input int i);
        logic bub, exb, frz, fl, pc;
        logic [1:0] st;
        bub = 1'b0; exb = 1'b0; frz = 1'b0; fl = 1'b0; pc = 1'b0;
        if (!rst) return 9'd0;
        st = (lu_rem[i] > 0) ? 2'd1 : (pmw[i] ? 2'd2 : 2'd0);
        if (lu_rem[i] > 0) begin bub = 1'b1; exb = 1'b1; frz = mwait(); end
        else if (mwait()) begin frz = 1'b1; bub = 1'b1; end
        else if (ex_br_taken) begin fl = 1'b1; pc = 1'b1; end
        else if (hz()) begin bub = 1'b1; exb = 1'b1; end
        else pc = 1'b1;
        return {bub, exb, frz, fl, fl, pc, (sq[i] != 0), st};
    endfunction

    function automatic logic [8:0] obs_vec(input int i);
        if (i == 0) return {a_bub, a_exb, a_frz, a_fif, a_fie, a_pc, a_sqa, a_state};
        return {b_bub, b_exb, b_frz, b_fif, b_fie, b_pc, b_sqa, b_state};
    endfunction

    function automatic longint obs_stall(input int i);
        return (i == 0) ? longint'(a_stall) : longint'(b_stall);
    endfunction

    function automatic longint obs_flush(input int i);
        return (i == 0) ? longint'(a_flush) : longint'(b_flush);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            lu_rem[i] = 0; sq[i] = 0; stall[i] = 0; flushes[i] = 0; pmw[i] = 1'b0;
        end
    endtask

    task automatic commit(input int i);
        bit frz, reload, bub;
        frz = 1'b0; reload = 1'b0; bub = 1'b0;
        if (!rst) begin
            lu_rem[i] = 0; sq[i] = 0; stall[i] = 0; flushes[i] = 0; pmw[i] = 1'b0;
            return;
        end
        if (lu_rem[i] > 0) begin
            bub = 1'b1; pmw[i] = 1'b0;
            if (mwait()) frz = 1'b1; else lu_rem[i]--;
        end else if (mwait()) begin
            frz = 1'b1; bub = 1'b1; pmw[i] = 1'b1;
        end else begin
            pmw[i] = 1'b0;
            if (ex_br_taken) begin
                reload = 1'b1;
                if (flushes[i] < maxc[i]) flushes[i]++;
            end else if (hz()) begin
                bub = 1'b1; lu_rem[i] = luc[i] - 1;
            end
        end
        if (reload) sq[i] = fd[i];
        else if (!frz && sq[i] > 0) sq[i]--;
        if (bub && stall[i] < maxc[i]) stall[i]++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        commit(0);
        commit(1);
    endtask

    task automatic idle();
        id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0;
        ex_is_load = 1'b0; ex_rd = 5'd0; ex_br_taken = 1'b0;
        imem_resp = 1'b1; dmem_req = 1'b0; dmem_resp = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        ex_br_taken = 1'b1; imem_resp = 1'b0; dmem_req = 1'b1; dmem_resp = 1'b0;
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1'b1;
        id_rs2 = 5'd0; id_uses_rs2 = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_vec(i) !== 9'd0 || obs_stall(i) != 0 || obs_flush(i) != 0) begin
                miscompares++;
                $display("FAIL reset_hold dut%0d got %h stall %0d flush %0d, expected all zero",
                         i, obs_vec(i), obs_stall(i), obs_flush(i));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        idle();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_vec(i) !== 9'h008 || exp_vec(i) !== 9'h008) begin
                miscompares++;
                $display("FAIL reset_release dut%0d got %h model %h expected 008", i, obs_vec(i), exp_vec(i));
            end
        end
        tick();
    endtask

    task automatic test_load_use();
        int nb[2];
        nb[0] = 0; nb[1] = 0;
        idle();
        ex_is_load = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_uses_rs2 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                nb[i] += int'(obs_vec(i)[8]);
                vectors++;
                if (obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL load_use c%0d dut%0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            tick();
            if (c == 0) idle();
        end
        vectors++;
        if (nb[0] != 1 || nb[1] != 3 || a_stall != 32'd1 || b_stall != 4'd3) begin
            miscompares++;
            $display("FAIL load_use_len got %0d/%0d stall %0d/%0d expected 1/3 stall 1/3",
                     nb[0], nb[1], a_stall, b_stall);
        end
    endtask

    task automatic test_x0();
        for (int p = 0; p < 2; p++) begin
            idle();
            ex_is_load = 1'b1;
            if (p == 0) begin ex_rd = 5'd0; id_rs1 = 5'd0; id_uses_rs1 = 1'b1; end
            else begin ex_rd = 5'd7; id_rs1 = 5'd7; id_uses_rs1 = 1'b0; end
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i)[8] !== 1'b0 || obs_vec(i) !== exp_vec(i)) begin
                    miscompares++;
                    $display("FAIL no_hazard p%0d dut%0d got %h expected %h", p, i, obs_vec(i), exp_vec(i));
                end
            end
            tick();
        end
        idle();
    endtask

    task automatic test_branch();
        logic [5:0] pat[2];
        pat[0] = 6'b000001;
        pat[1] = 6'b000011;
        for (int p = 0; p < 2; p++) begin
            int nsq[2];
            nsq[0] = 0; nsq[1] = 0;
            for (int c = 0; c < 6; c++) begin
                idle();
                ex_br_taken = pat[p][c];
                @(negedge clk);
                for (int i = 0; i < 2; i++) begin
                    if (c > p) nsq[i] += int'(obs_vec(i)[2]);
                    vectors++;
                    if (obs_vec(i) !== exp_vec(i) || (ex_br_taken && obs_vec(i)[5:4] !== 2'b11)) begin
                        miscompares++;
                        $display("FAIL branch p%0d c%0d dut%0d got %h expected %h", p, c, i, obs_vec(i), exp_vec(i));
                    end
                end
                tick();
            end
            vectors++;
            if (nsq[0] != 2 || nsq[1] != 3) begin
                miscompares++;
                $display("FAIL squash_len p%0d got %0d/%0d expected 2/3", p, nsq[0], nsq[1]);
            end
        end
        vectors++;
        if (a_flush != 32'd3 || b_flush != 4'd3) begin
            miscompares++;
            $display("FAIL flush_count got %0d/%0d expected 3/3", a_flush, b_flush);
        end
        idle();
    endtask

    task automatic test_mem_wait();
        idle();
        ex_br_taken = 1'b1;
        tick();
        dmem_req = 1'b1; dmem_resp = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 4) dmem_resp = 1'b1;
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i) || obs_vec(i)[2] !== 1'b1 ||
                    obs_vec(i)[6] !== (c < 4) || obs_vec(i)[5] !== (c == 4)) begin
                    miscompares++;
                    $display("FAIL mem_wait c%0d dut%0d got %h expected %h", c, i, obs_vec(i), exp_vec(i));
                end
            end
            tick();
        end
        idle();
        tick();
    endtask

    task automatic test_saturation_async_reset();
        idle();
        dmem_req = 1'b1;
        repeat (20) tick();
        idle();
        @(negedge clk);
        vectors++;
        if (b_stall != 4'd15 || longint'(a_stall) != stall[0]) begin
            miscompares++;
            $display("FAIL stall_sat got %0d/%0d expected 15/%0d", b_stall, a_stall, stall[0]);
        end
        tick();
        ex_is_load = 1'b1; ex_rd = 5'd9; id_rs1 = 5'd9; id_uses_rs1 = 1'b1;
        tick();
        idle();
        #2;
        rst = 1'b0;
        #1;
        vectors++;
        if (obs_vec(0) !== 9'd0 || obs_vec(1) !== 9'd0 || b_stall != 4'd0 || a_stall != 32'd0) begin
            miscompares++;
            $display("FAIL async_reset got %h/%h stall %0d/%0d expected zero",
                     obs_vec(0), obs_vec(1), a_stall, b_stall);
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            vectors++;
            if (obs_vec(i) !== 9'h008) begin
                miscompares++;
                $display("FAIL post_reset dut%0d got %h expected 008", i, obs_vec(i));
            end
        end
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            id_rs1 = 5'($urandom_range(0, 3));
            id_rs2 = 5'($urandom_range(0, 3));
            ex_rd = 5'($urandom_range(0, 3));
            id_uses_rs1 = 1'($urandom_range(0, 1));
            id_uses_rs2 = 1'($urandom_range(0, 1));
            ex_is_load = ($urandom_range(0, 2) != 0);
            ex_br_taken = ($urandom_range(0, 5) == 0);
            imem_resp = ($urandom_range(0, 7) != 0);
            dmem_req = ($urandom_range(0, 3) == 0);
            dmem_resp = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                vectors++;
                if (obs_vec(i) !== exp_vec(i) || obs_stall(i) != stall[i] || obs_flush(i) != flushes[i]) begin
                    miscompares++;
                    $display("FAIL random c%0d dut%0d got %h/%0d/%0d expected %h/%0d/%0d", c, i,
                             obs_vec(i), obs_stall(i), obs_flush(i), exp_vec(i), stall[i], flushes[i]);
                end
            end
            tick();
        end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_load_use();
        test_x0();
        test_branch();
        test_mem_wait();
        test_saturation_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
